// File: rtl/esw_mport_dispatch.sv
// Store-and-forward packet dispatcher: buffers whole packets, then unicasts/multicasts them to PORT_NUM egress ports.
// Latency: first egress word 3 cycles after end-of-packet; egress waits while any selected port is almost-full.
module esw_mport_dispatch #(
  parameter int PORT_NUM      = 4,
  parameter int DATA_AW       = 8,
  parameter int ACT_AW        = 4,
  parameter int MAX_PKT_WORDS = 96
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [133:0]             in_disp_data,
  input  logic                     in_disp_data_wr,
  input  logic                     in_disp_valid,
  input  logic                     in_disp_valid_wr,
  input  logic [PORT_NUM-1:0]      in_disp_action,
  input  logic                     in_disp_action_wr,
  input  logic [PORT_NUM-1:0]      in_port_alf,
  output logic [PORT_NUM*134-1:0]  out_port_data,
  output logic [PORT_NUM-1:0]      out_port_data_wr,
  output logic [PORT_NUM-1:0]      out_port_valid,
  output logic [PORT_NUM-1:0]      out_port_valid_wr,
  output logic [63:0]              disp_pktin_cnt,
  output logic [31:0]              disp_drop_cnt,
  output logic [PORT_NUM*32-1:0]   disp_pktout_cnt
);

  localparam int DEPTH  = 1 << DATA_AW;
  localparam int ADEPTH = 1 << ACT_AW;
  localparam int LW     = DATA_AW + 1;
  localparam logic [LW-1:0]     MAXW    = LW'(MAX_PKT_WORDS);
  localparam logic [LW-1:0]     DEPTHW  = LW'(DEPTH);
  localparam logic [ACT_AW:0]   ADEPTHW = (ACT_AW+1)'(ADEPTH);

  typedef struct packed {
    logic [PORT_NUM-1:0] bitmap;
    logic [DATA_AW-1:0]  start;
    logic [LW-1:0]       len;
  } desc_t;

  typedef enum logic [1:0] {IDLE, RD, SEND} eg_state_t;

  logic [133:0] mem [DEPTH];
  desc_t        act_mem [ADEPTH];

  // Pointers carry one extra bit so a completely full buffer is distinguishable from empty.
  logic [LW-1:0]        wr_ptr, rd_ptr, used, free;
  logic [LW-1:0]        in_len, new_len;
  logic                 in_pkt, in_drop;
  logic [PORT_NUM-1:0]  in_bitmap;
  logic                 is_head, body_wr, admit, commit_ev, commit_ok;
  logic                 mem_we;
  logic [DATA_AW-1:0]   mem_waddr;
  logic [63:0]          pktin_q;
  logic [31:0]          drop_q;

  logic [ACT_AW-1:0]    act_wp, act_rp;
  logic [ACT_AW:0]      act_cnt;
  logic                 act_full, act_push, act_pop;
  desc_t                push_desc, head_desc;

  eg_state_t            state;
  logic [PORT_NUM-1:0]  eg_bm;
  logic [DATA_AW-1:0]   eg_addr;
  logic [LW-1:0]        eg_rem;
  logic                 rd_en;
  logic [133:0]         rd_data, out_word;
  logic [PORT_NUM-1:0]  out_wr, out_vwr, out_v;
  logic [31:0]          pkt_out [PORT_NUM];

  assign used     = wr_ptr - rd_ptr;
  assign free     = DEPTHW - used;
  assign act_full = (act_cnt == ADEPTHW);
  assign admit    = (free >= MAXW) && !act_full;

  assign is_head   = in_disp_data_wr && (in_disp_data[133:132] == 2'b01);
  assign body_wr   = in_disp_data_wr && !is_head && in_pkt;
  assign new_len   = in_len + LW'(in_disp_data_wr);
  assign commit_ev = in_disp_valid_wr && in_pkt && !is_head;
  assign commit_ok = commit_ev && !in_drop && (in_len != MAXW) && in_disp_valid && (|in_bitmap);

  // Words of a packet land at wr_ptr + offset; wr_ptr only moves on commit, so rollback is free.
  assign mem_we    = is_head ? admit : (body_wr && !in_drop && (in_len != MAXW));
  assign mem_waddr = is_head ? wr_ptr[DATA_AW-1:0]
                             : wr_ptr[DATA_AW-1:0] + in_len[DATA_AW-1:0];

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= in_disp_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      in_pkt    <= 1'b0;
      in_drop   <= 1'b0;
      in_len    <= '0;
      in_bitmap <= '0;
      pktin_q   <= '0;
      drop_q    <= '0;
    end else begin
      if (is_head) begin
        in_pkt    <= 1'b1;
        in_drop   <= !admit;
        in_len    <= LW'(1);
        in_bitmap <= in_disp_action_wr ? in_disp_action : '0;
      end else if (body_wr) begin
        if (in_len == MAXW) in_drop <= 1'b1;
        else                in_len  <= in_len + 1'b1;
      end
      if (commit_ev) begin
        in_pkt <= 1'b0;
        if (commit_ok) begin
          wr_ptr  <= wr_ptr + new_len;
          pktin_q <= pktin_q + 1'b1;
        end else begin
          drop_q  <= drop_q + 1'b1;
        end
      end
    end
  end

  assign act_push  = commit_ok;
  assign push_desc = '{bitmap: in_bitmap, start: wr_ptr[DATA_AW-1:0], len: new_len};
  assign head_desc = act_mem[act_rp];
  assign act_pop   = (state == IDLE) && (act_cnt != '0) && ((in_port_alf & head_desc.bitmap) == '0);

  always_ff @(posedge clk) begin
    if (act_push) act_mem[act_wp] <= push_desc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_wp  <= '0;
      act_rp  <= '0;
      act_cnt <= '0;
    end else begin
      if (act_push) act_wp <= act_wp + 1'b1;
      if (act_pop)  act_rp <= act_rp + 1'b1;
      act_cnt <= act_cnt + (ACT_AW+1)'(act_push) - (ACT_AW+1)'(act_pop);
    end
  end

  // rd_data prefetches one word ahead so SEND can emit a word every cycle.
  assign rd_en = (state == RD) || (state == SEND);

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[eg_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      eg_bm    <= '0;
      eg_addr  <= '0;
      eg_rem   <= '0;
      rd_ptr   <= '0;
      out_word <= '0;
      out_wr   <= '0;
      out_vwr  <= '0;
      out_v    <= '0;
      for (int i = 0; i < PORT_NUM; i++) pkt_out[i] <= '0;
    end else begin
      out_wr  <= '0;
      out_vwr <= '0;
      out_v   <= '0;
      case (state)
        IDLE: begin
          if (act_pop) begin
            eg_bm   <= head_desc.bitmap;
            eg_addr <= head_desc.start;
            eg_rem  <= head_desc.len;
            state   <= RD;
          end
        end
        RD: begin
          eg_addr <= eg_addr + 1'b1;
          state   <= SEND;
        end
        SEND: begin
          out_word <= rd_data;
          out_wr   <= eg_bm;
          eg_addr  <= eg_addr + 1'b1;
          eg_rem   <= eg_rem - 1'b1;
          rd_ptr   <= rd_ptr + 1'b1;
          if (eg_rem == LW'(1)) begin
            out_vwr <= eg_bm;
            out_v   <= eg_bm;
            state   <= IDLE;
            for (int i = 0; i < PORT_NUM; i++)
              if (eg_bm[i]) pkt_out[i] <= pkt_out[i] + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_port_data     = {PORT_NUM{out_word}};
  assign out_port_data_wr  = out_wr;
  assign out_port_valid    = out_v;
  assign out_port_valid_wr = out_vwr;
  assign disp_pktin_cnt    = pktin_q;
  assign disp_drop_cnt     = drop_q;

  for (genvar g = 0; g < PORT_NUM; g++) begin : g_cnt
    assign disp_pktout_cnt[32*g +: 32] = pkt_out[g];
  end

endmodule

// File: tb/tb_esw_mport_dispatch.sv
// Directed bench for esw_mport_dispatch with a per-port expected-word scoreboard.
module tb_esw_mport_dispatch;
  localparam int PN = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [133:0]        in_disp_data = '0;
  logic                in_disp_data_wr = 1'b0;
  logic                in_disp_valid = 1'b0;
  logic                in_disp_valid_wr = 1'b0;
  logic [PN-1:0]       in_disp_action = '0;
  logic                in_disp_action_wr = 1'b0;
  logic [PN-1:0]       in_port_alf = '0;
  logic [PN*134-1:0]   out_port_data;
  logic [PN-1:0]       out_port_data_wr, out_port_valid, out_port_valid_wr;
  logic [63:0]         disp_pktin_cnt;
  logic [31:0]         disp_drop_cnt;
  logic [PN*32-1:0]    disp_pktout_cnt;

  always #5 clk = ~clk;

  esw_mport_dispatch #(.PORT_NUM(PN), .DATA_AW(8), .ACT_AW(4), .MAX_PKT_WORDS(96)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_disp_data(in_disp_data), .in_disp_data_wr(in_disp_data_wr),
    .in_disp_valid(in_disp_valid), .in_disp_valid_wr(in_disp_valid_wr),
    .in_disp_action(in_disp_action), .in_disp_action_wr(in_disp_action_wr),
    .in_port_alf(in_port_alf),
    .out_port_data(out_port_data), .out_port_data_wr(out_port_data_wr),
    .out_port_valid(out_port_valid), .out_port_valid_wr(out_port_valid_wr),
    .disp_pktin_cnt(disp_pktin_cnt), .disp_drop_cnt(disp_drop_cnt),
    .disp_pktout_cnt(disp_pktout_cnt)
  );

  typedef struct packed {
    logic [PN-1:0] mask;
    logic          vw;
    logic          v;
    logic [133:0]  dat;
  } exp_t;

  exp_t   exp_q [PN][$];
  int     checks = 0;
  int     errors = 0;
  int     rx_cnt [PN];
  longint exp_in = 0;
  int     exp_drop = 0;
  int     exp_out [PN];
  int     lat;
  int     rx_before;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Output monitor: each emitted word must match the oldest expected word for that port.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < PN; i++) begin
        if (out_port_data_wr[i]) begin
          rx_cnt[i]++;
          if (exp_q[i].size() == 0) begin
            chk($sformatf("unexpected_word_p%0d", i), 136'(out_port_data_wr[i]), 136'(0));
          end else begin
            e = exp_q[i].pop_front();
            chk($sformatf("data_p%0d", i), 136'(out_port_data[134*i +: 134]), 136'(e.dat));
            chk($sformatf("wr_mask_p%0d", i), 136'(out_port_data_wr), 136'(e.mask));
            chk($sformatf("eop_p%0d", i), 136'({out_port_valid_wr[i], out_port_valid[i]}),
                136'({e.vw, e.v}));
          end
        end
      end
    end
  end

  function automatic bit all_empty();
    for (int i = 0; i < PN; i++) if (exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int rx_total();
    int s = 0;
    for (int i = 0; i < PN; i++) s += rx_cnt[i];
    return s;
  endfunction

  // Drives one packet; called at posedge+1, returns at posedge+1 after the tail was sampled.
  task automatic send_pkt(input int n, input logic [PN-1:0] bm, input logic good, input logic pass);
    logic [133:0] w;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      w[133:132] = (k == 0) ? 2'b01 : ((k == n-1) ? 2'b10 : 2'b11);
      w[131:128] = (k == n-1) ? 4'($urandom_range(0, 15)) : 4'h0;
      w[127:0]   = {$urandom, $urandom, $urandom, $urandom};
      in_disp_data      = w;
      in_disp_data_wr   = 1'b1;
      in_disp_action    = bm;
      in_disp_action_wr = (k == 0);
      in_disp_valid_wr  = (k == n-1);
      in_disp_valid     = (k == n-1) ? good : 1'b0;
      if (pass) begin
        e.mask = bm;
        e.vw   = (k == n-1);
        e.v    = (k == n-1);
        e.dat  = w;
        for (int i = 0; i < PN; i++) if (bm[i]) exp_q[i].push_back(e);
      end
      @(posedge clk); #1;
    end
    in_disp_data_wr   = 1'b0;
    in_disp_action_wr = 1'b0;
    in_disp_valid_wr  = 1'b0;
    in_disp_valid     = 1'b0;
    if (pass) begin
      exp_in++;
      for (int i = 0; i < PN; i++) if (bm[i]) exp_out[i]++;
    end else begin
      exp_drop++;
    end
  endtask

  task automatic meas_lat(output int l);
    l = 0;
    while (l < 30 && out_port_data_wr == '0) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    int n = 0;
    while (n < max_cyc && !all_empty()) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(tag, 136'(all_empty()), 136'(1));
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_pktin"}, 136'(disp_pktin_cnt), 136'(exp_in));
    chk({tag, "_drop"},  136'(disp_drop_cnt),  136'(exp_drop));
    for (int i = 0; i < PN; i++)
      chk($sformatf("%s_pktout%0d", tag, i), 136'(disp_pktout_cnt[32*i +: 32]), 136'(exp_out[i]));
  endtask

  initial begin
    for (int i = 0; i < PN; i++) begin rx_cnt[i] = 0; exp_out[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_wr",  136'(out_port_data_wr),  136'(0));
    chk("rst_valid_wr", 136'(out_port_valid_wr), 136'(0));
    check_counters("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unicast with latency measurement
    send_pkt(4, 4'b0010, 1'b1, 1'b1);
    meas_lat(lat);
    chk("uni_latency", 136'(lat), 136'(3));
    wait_drain("uni_drain", 50);
    check_counters("uni");

    // Multicast
    send_pkt(10, 4'b1011, 1'b1, 1'b1);
    wait_drain("mc_drain", 60);
    check_counters("mc");

    // Bad packet and zero-bitmap packet between good ones
    send_pkt(5, 4'b0001, 1'b1, 1'b1);
    send_pkt(6, 4'b0001, 1'b0, 1'b0);
    send_pkt(3, 4'b0001, 1'b1, 1'b1);
    send_pkt(4, 4'b0000, 1'b1, 1'b0);
    wait_drain("bad_drain", 80);
    check_counters("bad");

    // Almost-full hold with head-of-line blocking
    in_port_alf = 4'b0100;
    send_pkt(4, 4'b0100, 1'b1, 1'b1);
    send_pkt(3, 4'b0001, 1'b1, 1'b1);
    rx_before = rx_total();
    repeat (20) @(posedge clk);
    #1;
    chk("alf_hold", 136'(rx_total()), 136'(rx_before));
    in_port_alf = 4'b0000;
    meas_lat(lat);
    chk("alf_release_lat", 136'(lat <= 3), 136'(1));
    wait_drain("alf_drain", 60);
    check_counters("alf");

    // Fill: third 96-word packet must be refused for lack of space
    in_port_alf = 4'b1111;
    send_pkt(96, 4'b0001, 1'b1, 1'b1);
    send_pkt(96, 4'b0001, 1'b1, 1'b1);
    send_pkt(96, 4'b0001, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("fill_drop", 136'(disp_drop_cnt), 136'(exp_drop));
    in_port_alf = 4'b0000;
    wait_drain("fill_drain", 600);
    check_counters("fill");
    send_pkt(96, 4'b0001, 1'b1, 1'b1);
    send_pkt(5, 4'b1100, 1'b1, 1'b1);
    wait_drain("wrap_drain", 400);
    check_counters("wrap");

    // Reset in the middle of an egress packet
    send_pkt(20, 4'b0001, 1'b1, 1'b1);
    meas_lat(lat);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_data_wr",  136'(out_port_data_wr),  136'(0));
    chk("midrst_valid_wr", 136'(out_port_valid_wr), 136'(0));
    for (int i = 0; i < PN; i++) begin exp_q[i].delete(); exp_out[i] = 0; end
    exp_in = 0;
    exp_drop = 0;
    check_counters("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_pkt(4, 4'b0001, 1'b1, 1'b1);
    meas_lat(lat);
    chk("post_rst_latency", 136'(lat), 136'(3));
    wait_drain("post_rst_drain", 50);
    check_counters("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/esw_mport_dispatch.md
Name: esw_mport_dispatch

Overview:
- Parametrised successor to the fixed two-GOE-port packet action stage at the tail of the ESW pipeline.
- Accepts 134-bit packet words plus a per-packet port bitmap action from the forwarding stage, and buffers whole packets in store-and-forward mode.
- Unicasts, multicasts or discards each packet across PORT_NUM egress ports with per-port almost-full backpressure.
- Keeps per-port output counters and ingress/drop counters for LCM readout.

Parameters:
PORT_NUM, 4, number of egress ports (2..8)
DATA_AW, 8, log2 depth of packet word buffer (256 words)
ACT_AW, 4, log2 depth of action/descriptor FIFO (16 entries)
MAX_PKT_WORDS, 96, worst-case packet length in words (1536 B); admission threshold

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_disp_data  in  134  [133:132] 01=head, 11=body, 10=tail; [131:128] invalid byte count (tail only); [127:0] payload
in_disp_data_wr  in  1  word strobe
in_disp_valid  in  1  packet good (1) / bad (0), sampled with valid_wr
in_disp_valid_wr  in  1  end-of-packet strobe; same cycle as tail data_wr
in_disp_action  in  PORT_NUM  egress port bitmap
in_disp_action_wr  in  1  action strobe; same cycle as head data_wr
in_port_alf  in  PORT_NUM  per-port almost-full from egress
out_port_data  out  PORT_NUM*134  egress words; port i at [134*i+:134]
out_port_data_wr  out  PORT_NUM  per-port word strobe
out_port_valid  out  PORT_NUM  per-port packet good
out_port_valid_wr  out  PORT_NUM  per-port end-of-packet strobe
disp_pktin_cnt  out  64  packets committed to buffer
disp_drop_cnt  out  32  packets dropped (admission, bad, zero bitmap)
disp_pktout_cnt  out  PORT_NUM*32  packets sent per port; port i at [32*i+:32]

Behaviour:
- Reset: clk single domain; rst_n asynchronous, active-low. All outputs, counters, pointers 0; FSM IDLE.
- Admission (on head word):
  - Free words = 2^DATA_AW - used.
  - If free < MAX_PKT_WORDS or action FIFO full: whole packet dropped (no writes); drop_cnt+1 at its valid_wr.
  - Otherwise words are written at wr_ptr and packet start is saved in pkt_start.
- Commit (at valid_wr):
  - Committed if valid=1 and bitmap nonzero: wr_ptr advances past tail; {bitmap, start, len} pushed to action FIFO; pktin_cnt+1.
  - Else wr_ptr rolls back to pkt_start; drop_cnt+1.
  - Commit and egress free in the same cycle are both applied.
- Pointers wrap modulo 2^DATA_AW. used = commit-pointer minus read-pointer (in-flight words reserved by the admission check).
- Egress FSM:
  - IDLE: if action FIFO non-empty and (in_port_alf & bitmap)==0, pop descriptor -> RD.
  - RD: issue buffer read (1-cycle synchronous RAM) -> SEND.
  - SEND: one word per cycle to every port in bitmap; unselected ports see data_wr=0.
    - Tail word: valid_wr=1, valid=1 on selected ports, same cycle; pktout_cnt[i]+1 per selected port -> IDLE.
    - in_port_alf rising mid-packet is ignored; the packet completes (alf margin is egress's responsibility).
- Latency:
  - Committed packet into an empty block with ports ready: first output word 3 cycles after valid_wr.
  - Minimum 1 idle cycle between back-to-back egress packets.
- Egress data words are unmodified (bit-exact).
- Counters wrap silently at their width.
- Ingress protocol errors (body without head) are ignored; words are discarded until the next head.

Test Plan:
- Single 4-word good packet, bitmap 4'b0010 -> port1 gets 4 identical words, valid_wr with valid=1 on tail, first word 3 cycles after input valid_wr; pktin_cnt=1, pktout_cnt[1]=1, other ports silent.
- Multicast bitmap 4'b1011, 10-word packet -> ports 0, 1, 3 emit identical streams in the same cycles; each pktout_cnt=1.
- Bad packet (valid=0 at tail) between two good ones -> only the two good packets emerge, in order; drop_cnt=1; buffer used returns to 0.
- in_port_alf[2]=1 with a queued bitmap 4'b0100 packet -> no output until alf clears; then sends within 3 cycles. Head-of-line: a later packet for port0 also waits.
- Fill: back-to-back 96-word packets with all alf=1 -> the 2nd packet is admitted (256-96=160 free ≥ 96), the 3rd is dropped (64 free), drop_cnt=1; releasing alf drains both; pointers wrap correctly on a subsequent 5th packet.
- Assert rst_n low mid-SEND -> all out_port_data_wr/valid_wr drop to 0 immediately, counters 0; a post-reset packet passes normally.
